// File: rtl/sisc_pkg.sv
// Shared constants for the SISC core: opcodes, ALU operation codes,
// FSM state encoding and status-register bit positions.
package sisc_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ALU_R = 4'h1;
    localparam logic [3:0] OP_ALU_I = 4'h2;
    localparam logic [3:0] OP_BRA   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOT = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    // Status register layout is {C,V,N,Z}
    localparam int unsigned STAT_Z = 0;
    localparam int unsigned STAT_N = 1;
    localparam int unsigned STAT_V = 2;
    localparam int unsigned STAT_C = 3;

endpackage

// File: rtl/sisc_rf.sv
// Register file: two asynchronous read ports, one synchronous write port.
// Register 0 is hard-wired to zero and ignores writes.
module sisc_rf #(
    parameter int DATA_W = 32,
    parameter int RF_AW  = 4
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic [RF_AW-1:0]  rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [RF_AW-1:0]  rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [RF_AW-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int unsigned DEPTH = 1 << RF_AW;

    logic [DATA_W-1:0] regs [DEPTH];

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write returns the old value
    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/sisc_core.sv
// Multi-cycle SISC core: START/FETCH/DECODE/EXECUTE/WRITEBACK/HALT sequencer,
// ALU, status register and program counter around the sisc_rf register file.
module sisc_core
    import sisc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RF_AW  = 4,
    parameter int PC_W   = 16
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic [31:0]     ir_in,
    input  logic            ir_valid,
    output logic            fetch_req,
    output logic [PC_W-1:0] pc_out,
    output logic [3:0]      stat_out,
    output logic            halted
);

    localparam int MSB = DATA_W - 1;
    localparam logic [DATA_W-1:0] SH_LIM = DATA_W'(DATA_W);

    state_t            state;
    logic [31:0]       ir;
    logic [PC_W-1:0]   pc;
    logic [3:0]        stat;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] result;

    logic [3:0]        opcode;
    logic [3:0]        mm;
    logic [RF_AW-1:0]  rs_addr;
    logic [RF_AW-1:0]  rt_addr;
    logic [RF_AW-1:0]  rd_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              wr_en;
    logic [RF_AW-1:0]  wr_addr;

    alu_op_t           alu_op;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_v;
    logic [3:0]        stat_alu;

    assign opcode  = ir[31:28];
    assign mm      = ir[27:24];
    assign rs_addr = ir[20 +: RF_AW];
    assign rt_addr = ir[16 +: RF_AW];
    assign rd_addr = ir[12 +: RF_AW];
    assign alu_op  = alu_op_t'(mm[2:0]);

    assign wr_en   = (state == ST_WRITEBACK);
    assign wr_addr = (opcode == OP_ALU_R) ? rd_addr : rt_addr;

    assign pc_out   = pc;
    assign stat_out = stat;

    sisc_rf #(
        .DATA_W(DATA_W),
        .RF_AW (RF_AW)
    ) u_rf (
        .clk      (clk),
        .rst_f    (rst_f),
        .rd_addr_a(rs_addr),
        .rd_data_a(rs_data),
        .rd_addr_b(rt_addr),
        .rd_data_b(rt_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (result)
    );

    // SUB is a + ~b + 1, so the carry-out is the no-borrow flag directly
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sum     = {1'b0, op_a} + {1'b0, op_b};
        diff    = {1'b0, op_a} + {1'b0, ~op_b} + (DATA_W+1)'(1);
        case (alu_op)
            ALU_ADD: begin
                alu_res = sum[MSB:0];
                alu_c   = sum[DATA_W];
                alu_v   = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
            end
            ALU_SUB: begin
                alu_res = diff[MSB:0];
                alu_c   = diff[DATA_W];
                alu_v   = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
            end
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_XOR: alu_res = op_a ^ op_b;
            ALU_NOT: alu_res = ~op_a;
            ALU_SHL: alu_res = (op_b >= SH_LIM) ? '0 : (op_a << op_b);
            ALU_SHR: alu_res = (op_b >= SH_LIM) ? '0 : (op_a >> op_b);
            default: alu_res = '0;
        endcase
        stat_alu         = '0;
        stat_alu[STAT_C] = alu_c;
        stat_alu[STAT_V] = alu_v;
        stat_alu[STAT_N] = alu_res[MSB];
        stat_alu[STAT_Z] = (alu_res == '0);
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state     <= ST_START;
            ir        <= '0;
            pc        <= '0;
            stat      <= '0;
            op_a      <= '0;
            op_b      <= '0;
            result    <= '0;
            fetch_req <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                ST_START: begin
                    state     <= ST_FETCH;
                    fetch_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (ir_valid) begin
                        ir        <= ir_in;
                        pc        <= pc + PC_W'(1);
                        fetch_req <= 1'b0;
                        state     <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    op_a  <= rs_data;
                    op_b  <= (opcode == OP_ALU_I) ? DATA_W'(ir[15:0]) : rt_data;
                    state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    case (opcode)
                        OP_ALU_R, OP_ALU_I: begin
                            result <= alu_res;
                            stat   <= stat_alu;
                            state  <= ST_WRITEBACK;
                        end
                        OP_BRA: begin
                            if ((stat & mm) != 4'b0000) begin
                                pc <= PC_W'(ir[15:0]);
                            end
                            fetch_req <= 1'b1;
                            state     <= ST_FETCH;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end
                        default: begin
                            fetch_req <= 1'b1;
                            state     <= ST_FETCH;
                        end
                    endcase
                end
                ST_WRITEBACK: begin
                    fetch_req <= 1'b1;
                    state     <= ST_FETCH;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    fetch_req <= 1'b0;
                    state     <= ST_START;
                end
            endcase
        end
    end

endmodule

// File: doc/sisc_core.md
SISC_CORE -- requirements
Module: sisc_core

Interface
REQ-001 Parameter DATA_W, default 32, meaning datapath and register width; legal range 8..32.
REQ-002 Parameter RF_AW, default 4, meaning register address width; the register file has 2**RF_AW entries.
REQ-003 Parameter PC_W, default 16, meaning program counter width.
REQ-004 Port clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_f  in  1  reset, asynchronous, active-low.
REQ-006 Port ir_in  in  32  instruction word from memory: opcode[31:28], mm[27:24], rs[23:20], rt[19:16], rd[15:12], imm[15:0].
REQ-007 Port ir_valid  in  1  ir_in is valid this cycle.
REQ-008 Port fetch_req  out  1  core requests the instruction at pc_out.
REQ-009 Port pc_out  out  PC_W  current program counter.
REQ-010 Port stat_out  out  4  status register {C,V,N,Z} in bits [3:0].
REQ-011 Port halted  out  1  core is in HALT.

Function
REQ-012 The FSM SHALL have states START, FETCH, DECODE, EXECUTE, WRITEBACK and HALT.
REQ-013 START SHALL last one cycle, then go to FETCH.
REQ-014 In FETCH, fetch_req SHALL be 1; on ir_valid=1 the core SHALL latch ir_in, increment the PC (modulo 2**PC_W, all-ones wraps to 0) and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-015 DECODE SHALL read rs and rt, then go to EXECUTE.
REQ-016 Opcode 0 (NOP) SHALL do nothing in EXECUTE, then go to FETCH.
REQ-017 Opcode 1 (ALU reg): EXECUTE SHALL compute rd = rs op rt.
REQ-018 Opcode 2 (ALU imm): EXECUTE SHALL compute rt = rs op zero-extended imm, truncated to DATA_W.
REQ-019 For opcodes 1 and 2, mm[2:0] selects op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT rs, 6 SHL, 7 SHR (logical).
REQ-020 Shift amount SHALL be the second operand; amounts >= DATA_W SHALL give a result of 0.
REQ-021 ALU opcodes SHALL update stat in EXECUTE: Z = result==0; N = result MSB; C = carry-out (ADD) or no-borrow (SUB), else 0; V = signed overflow (ADD/SUB), else 0.
REQ-022 ALU opcodes SHALL go from EXECUTE to WRITEBACK, write the register file there, then go to FETCH.
REQ-023 Opcode 4 (BRA): in EXECUTE, if (stat & mm) != 0 then pc = imm[PC_W-1:0], else the PC is unchanged; then go to FETCH; stat SHALL NOT change.
REQ-024 Opcode 4 with mm=0 SHALL never branch.
REQ-025 Opcode 15 (HALT) SHALL enter HALT; HALT SHALL hold fetch_req=0 and halted=1 until reset.
REQ-026 Undefined opcodes SHALL execute as NOP.
REQ-027 Register 0 SHALL read 0; writes to it SHALL be discarded, including the stat update side effect being kept.
REQ-028 A write and a read of the same register in the same cycle SHALL return the old value; FSM sequencing guarantees no hazard.
REQ-029 Latency: for an ALU instruction, the register is updated 3 cycles after the ir_valid acceptance edge; the next fetch_req is asserted on cycle 4.
REQ-030 ir_valid outside FETCH SHALL be ignored.

Reset
REQ-031 On rst_f=0, asynchronously: state = START, pc = 0, stat = 0, latched IR = 0, fetch_req = 0, halted = 0.
REQ-032 The register file SHALL be cleared to 0 on reset.
REQ-033 Reset mid-instruction SHALL discard any pending writeback or branch.

Structure
REQ-034 Package sisc_pkg SHALL hold the opcode constants, the ALU op codes, the FSM state enum and the stat bit indices.
REQ-035 The register file SHALL be sub-module sisc_rf, parametrised by DATA_W and RF_AW, with two read ports and one write port.
REQ-036 ALU, status register and FSM SHALL be inside sisc_core.

Verification
REQ-037 Scenario: reset, then ir_valid held at 1 with NOP -> fetch_req=1 in cycle 2, pc_out increments by 1 every 3 cycles.
REQ-038 Scenario: ALU imm ADD R1=R0+0x0005, then ALU reg ADD R2=R1+R1 -> R2 = 10 and stat = 0000.
REQ-039 Scenario: SUB with R1=R2=5 -> result 0 and stat = {C=1,V=0,N=0,Z=1}; then BRA mm=0001, imm=0x0040 -> pc_out = 0x0040.
REQ-040 Scenario: ADD 0x7FFFFFFF+1 -> stat V=1, N=1; SHL by 32 -> result 0, Z=1.
REQ-041 Scenario: pc = 0xFFFF, then fetch -> pc_out = 0x0000; ALU write to R0 -> R0 still reads 0.
REQ-042 Scenario: rst_f low during WRITEBACK -> target register unchanged; HALT -> fetch_req stays 0 until rst_f is released.
